uart_delay_cmd_rx: RTL and testbench
====================================

// Module: uart_delay_cmd_rx
// PURPOSE
// - Next-generation UART delay-programming receiver on the AWG card, 10 MHz UART clock domain.
// - Deserialises 8N1 bytes from the buffered host line and assembles 8-byte (64-bit) command frames.
// - Filters frames on this card's geographic address (GA) and drives write ports for NUM_CH delay RAMs.
// - Beyond the fixed 4-port generation it adds:
//   - parametrised channel count and widths;
//   - broadcast writes and per-channel auto-incrementing write pointers;
//   - pointer-clear command;
//   - framing and inter-byte-timeout recovery with error reporting.
// PARAMETERS
// - NUM_CH        4     number of delay channels / RAM write ports (1..14)
// - ADDR_W        11    delay RAM address width
// - DATA_W        24    delay word width (<=24; frame delay field truncated to DATA_W LSBs)
// - CLKS_PER_BIT  10    I_clk_10M cycles per UART bit (>=4)
// - TIMEOUT_CLKS  2000  idle cycles between bytes after which a partial frame is discarded
// PORTS
// - I_clk_10M   in   1               UART clock
// - I_rst_n     in   1               asynchronous, active-low reset
// - rxb         in   1               serial line, idle high, async to clock
// - GA          in   5               card geographic address; GA[3:0] compared to frame[31:28]
// - O_WEA       out  NUM_CH          per-channel RAM write enable, 1-cycle pulse
// - O_WADDR     out  NUM_CH*ADDR_W   per-channel write address, ch k at [k*ADDR_W +: ADDR_W]
// - O_WDATA     out  NUM_CH*DATA_W   per-channel write data, same packing
// - O_frame_err out  1               1-cycle pulse on framing error, timeout or bad channel
// - O_err_cnt   out  8               saturating error count (stops at 255)
// - O_busy      out  1               high while a frame is partially received
// BEHAVIOUR
// - Reset: all outputs 0, all channel pointers 0, byte counter 0, rx FSM IDLE.
//   - Reset mid-frame discards the partial frame.
// - rxb passes a 2-flop synchroniser (preset to 1 on reset) before any use.
// - Byte FSM, all sampling at bit centres:
//   - IDLE -> START on synchronised falling edge.
//   - START: at CLKS_PER_BIT/2 line still 0 -> DATA; else glitch -> IDLE, no error.
//   - DATA: sample 8 bits every CLKS_PER_BIT, LSB first.
//   - STOP: sample at centre; 1 -> byte valid; 0 -> framing error.
//   - Framing error: discard frame, pulse O_frame_err, wait for line high, then IDLE.
// - Frame assembly:
//   - First byte received is frame[63:56], eighth byte is frame[7:0].
//   - O_busy = (byte_cnt != 0).
//   - Timeout: byte_cnt != 0 and no start bit for TIMEOUT_CLKS cycles
//     -> byte_cnt = 0, O_frame_err pulse, +1 err.
// - Decode, one cycle after the 8th stop bit:
//   - Fields: hdr = [63:32]; ga = [31:28]; ch = [27:24] (1-based); dly = [23:0].
//   - ga != GA[3:0]: frame silently ignored, not an error.
//   - hdr == CMD_WR (32'h0200_2000):
//     - ch in 1..NUM_CH: write to channel ch-1.
//     - ch == 4'hF: broadcast, every channel writes in the same cycle, each at its own pointer.
//     - any other ch: error pulse, no write.
//   - hdr == CMD_CLR (32'h0200_3000): clear pointer of channel ch-1, or of all channels if ch == 4'hF.
//   - Any other hdr: ignored, no error.
// - Write port timing:
//   - O_WEA[k] high for exactly 1 cycle, with O_WADDR/O_WDATA valid in the same cycle.
//   - O_WADDR/O_WDATA hold their values afterwards.
//   - The channel pointer increments the cycle after the write and wraps 2^ADDR_W-1 -> 0.
// - Latency: O_WEA rises on the 2nd clock after the stop-bit sample of byte 8.
// - Simultaneous events: a decode and a new start bit in the same cycle are independent (byte FSM is not stalled).
// - O_err_cnt increments on every O_frame_err pulse and saturates at 255.
// STRUCTURE
// - Package uart_delay_pkg:
//   - CMD_WR, CMD_CLR, BCAST_CH = 4'hF;
//   - field position localparams;
//   - frame typedef {hdr, ga, ch, dly}.
// - Sub-module uart_rx_byte:
//   - synchroniser plus byte FSM, parameter CLKS_PER_BIT;
//   - outputs byte[7:0], byte_vld pulse, frm_err pulse, idle flag.
// - Top level holds the frame shift register, timeout counter, decoder, NUM_CH pointers and output registers (generate loop).
// TESTING
// - Defaults, GA=5'd14; send bytes of 64'h02002000_e_1_00000a
//   -> WEA[0] pulse, WADDR ch0 = 0, WDATA ch0 = 24'h00000a; other WEA stay 0.
// - Then 64'h02002000_e_1_000014, followed by frames for ch 2/3/4 with dly 0x14/0x1e/0x28
//   -> ch0 addr 1 data 0x14; ch1/ch2/ch3 each at addr 0 with its data.
// - 64'h02002000_d_1_00000a (GA mismatch) -> no WEA, no error.
//   - Then 64'h02002000_e_f_000033 -> all 4 WEA in the same cycle, data 0x33 at each channel's pointer.
// - Byte 3 sent with stop bit 0 -> one O_frame_err pulse, err_cnt 1, no write.
//   - Next valid frame writes correctly.
// - 4 bytes sent, then idle > TIMEOUT_CLKS -> error pulse, O_busy falls.
//   - Full frame afterwards -> exactly one correct write.
// - 64'h02003000_e_1_000000 -> ch0 pointer cleared; next ch1 write at addr 0.
//   - 64'h02002000_e_5_000001 -> error pulse, no write.
//   - Reset asserted mid-byte -> outputs 0 and pointers 0 immediately.

Source files
------------

// File: rtl/uart_delay_pkg.sv
// Shared command codes, frame layout and field positions for the UART
// delay-programming receiver.
package uart_delay_pkg;

  localparam logic [31:0] CMD_WR   = 32'h0200_2000;
  localparam logic [31:0] CMD_CLR  = 32'h0200_3000;
  localparam logic [3:0]  BCAST_CH = 4'hF;

  localparam int FRAME_W = 64;
  localparam int HDR_LSB = 32;
  localparam int GA_LSB  = 28;
  localparam int CH_LSB  = 24;
  localparam int DLY_LSB = 0;

  typedef struct packed {
    logic [31:0] hdr;
    logic [3:0]  ga;
    logic [3:0]  ch;
    logic [23:0] dly;
  } frame_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop line synchroniser plus a bit-centre sampling FSM.
// Emits one-cycle byte_vld / frm_err pulses; idle is high only in RX_IDLE.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxb,
  output logic [7:0] data_byte,
  output logic       byte_vld,
  output logic       frm_err,
  output logic       idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // sync2 lags the line, so the edge detect already costs one cycle of the half bit
  localparam logic [CNT_W-1:0] HALF_M2 = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] RX_IDLE    = 3'd0;
  localparam logic [2:0] RX_START   = 3'd1;
  localparam logic [2:0] RX_DATA    = 3'd2;
  localparam logic [2:0] RX_STOP    = 3'd3;
  localparam logic [2:0] RX_WAIT_HI = 3'd4;

  logic             sync1_r, sync2_r, prev_r;
  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_vld_r, frm_err_r;

  // line synchroniser and edge history, preset to idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rxb;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // byte FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RX_IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      byte_vld_r <= 1'b0;
      frm_err_r  <= 1'b0;
    end else begin
      byte_vld_r <= 1'b0;
      frm_err_r  <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
          if (prev_r && !sync2_r) state_r <= RX_START;
        end
        RX_START: begin
          if (cnt_r == HALF_M2) begin
            cnt_r   <= '0;
            state_r <= sync2_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == FULL_M1) begin
            cnt_r     <= '0;
            shift_r   <= {sync2_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) state_r <= RX_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r <= '0;
            if (sync2_r) begin
              byte_vld_r <= 1'b1;
              state_r    <= RX_IDLE;
            end else begin
              frm_err_r <= 1'b1;
              state_r   <= RX_WAIT_HI;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_WAIT_HI: begin
          if (sync2_r) state_r <= RX_IDLE;
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

  assign data_byte = shift_r;
  assign byte_vld  = byte_vld_r;
  assign frm_err   = frm_err_r;
  assign idle      = (state_r == RX_IDLE);

endmodule

// File: rtl/uart_delay_cmd_rx.sv
// UART delay-programming receiver: assembles 8-byte frames, filters on GA and
// drives NUM_CH delay-RAM write ports with auto-incrementing pointers.
module uart_delay_cmd_rx
  import uart_delay_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 24,
  parameter int CLKS_PER_BIT = 10,
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic                       I_clk_10M,
  input  logic                       I_rst_n,
  input  logic                       rxb,
  input  logic [4:0]                 GA,
  output logic [NUM_CH-1:0]          O_WEA,
  output logic [NUM_CH*ADDR_W-1:0]   O_WADDR,
  output logic [NUM_CH*DATA_W-1:0]   O_WDATA,
  output logic                       O_frame_err,
  output logic [7:0]                 O_err_cnt,
  output logic                       O_busy
);

  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]        rx_byte_s;
  logic              byte_vld_s, rx_err_s, rx_idle_s;
  logic [63:0]       frame_r;
  frame_t            fr_s;
  logic [2:0]        byte_cnt_r;
  logic              dec_r;
  logic [TO_W-1:0]   tmo_cnt_r;
  logic              tmo_s, ch_ok_s, bad_ch_s, err_s;
  logic [NUM_CH-1:0] wr_s, clr_s;
  logic              frame_err_r;
  logic [7:0]        err_cnt_r;
  logic              unused_ga_s;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (I_clk_10M),
    .rst_n     (I_rst_n),
    .rxb       (rxb),
    .data_byte (rx_byte_s),
    .byte_vld  (byte_vld_s),
    .frm_err   (rx_err_s),
    .idle      (rx_idle_s)
  );

  assign fr_s        = frame_r;
  assign unused_ga_s = ^{GA[4], fr_s.dly};
  assign tmo_s       = (byte_cnt_r != 3'd0) && rx_idle_s &&
                       (tmo_cnt_r == TO_W'(TIMEOUT_CLKS - 1));
  assign ch_ok_s     = (fr_s.ch == BCAST_CH) ||
                       ((fr_s.ch != 4'd0) && ({28'd0, fr_s.ch} <= NUM_CH[31:0]));
  assign err_s       = rx_err_s | tmo_s | bad_ch_s;

  // frame shift register, byte counter and inter-byte timeout
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      frame_r    <= 64'd0;
      byte_cnt_r <= 3'd0;
      dec_r      <= 1'b0;
      tmo_cnt_r  <= '0;
    end else begin
      dec_r <= 1'b0;
      if (rx_err_s || tmo_s) begin
        byte_cnt_r <= 3'd0;
      end else if (byte_vld_s) begin
        frame_r    <= {frame_r[55:0], rx_byte_s};
        byte_cnt_r <= byte_cnt_r + 3'd1;
        dec_r      <= (byte_cnt_r == 3'd7);
      end
      if ((byte_cnt_r == 3'd0) || !rx_idle_s) tmo_cnt_r <= '0;
      else                                    tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
    end
  end

  // command decode of the completed frame
  always_comb begin
    wr_s     = '0;
    clr_s    = '0;
    bad_ch_s = 1'b0;
    if (dec_r && (fr_s.ga == GA[3:0]) && ((fr_s.hdr == CMD_WR) || (fr_s.hdr == CMD_CLR))) begin
      if (ch_ok_s) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (fr_s.hdr == CMD_WR) wr_s[k]  = (fr_s.ch == BCAST_CH) || (fr_s.ch == 4'(k + 1));
          else                    clr_s[k] = (fr_s.ch == BCAST_CH) || (fr_s.ch == 4'(k + 1));
        end
      end else begin
        bad_ch_s = 1'b1;
      end
    end else begin
      bad_ch_s = 1'b0;
    end
  end

  // error pulse and saturating error count
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      frame_err_r <= 1'b0;
      err_cnt_r   <= 8'd0;
    end else begin
      frame_err_r <= err_s;
      if (err_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      logic              wea_r;
      logic [ADDR_W-1:0] ptr_r, waddr_r;
      logic [DATA_W-1:0] wdata_r;

      // per-channel pointer and write-port registers; pointer advances after the write
      always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) begin
          wea_r   <= 1'b0;
          ptr_r   <= '0;
          waddr_r <= '0;
          wdata_r <= '0;
        end else begin
          wea_r <= wr_s[k];
          if (clr_s[k])   ptr_r <= '0;
          else if (wea_r) ptr_r <= ptr_r + ADDR_W'(1);
          if (wr_s[k]) begin
            waddr_r <= ptr_r;
            wdata_r <= fr_s.dly[DATA_W-1:0];
          end
        end
      end

      assign O_WEA[k]                     = wea_r;
      assign O_WADDR[k*ADDR_W +: ADDR_W]  = waddr_r;
      assign O_WDATA[k*DATA_W +: DATA_W]  = wdata_r;
    end
  endgenerate

  assign O_frame_err = frame_err_r;
  assign O_err_cnt   = err_cnt_r;
  assign O_busy      = (byte_cnt_r != 3'd0);

endmodule

// File: tb/tb_uart_delay_cmd_rx.sv
// Scoreboard bench for uart_delay_cmd_rx: stimulus pushes expected writes and
// error pulses, a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_delay_cmd_rx;

  localparam int NCH = 4;
  localparam int AW  = 11;
  localparam int DW  = 24;
  localparam int CPB = 10;
  localparam int TMO = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxb = 1'b1;
  logic [4:0]        ga = 5'd14;
  logic [NCH-1:0]    wea;
  logic [NCH*AW-1:0] waddr;
  logic [NCH*DW-1:0] wdata;
  logic              frame_err;
  logic [7:0]        err_cnt;
  logic              busy;

  typedef struct packed {
    logic [NCH-1:0]    mask;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] data;
  } wr_ev_t;

  wr_ev_t     wr_q[$];
  logic [7:0] err_q[$];
  int         ptr[NCH];
  int         exp_err = 0;
  int         checks = 0;
  int         errors = 0;

  uart_delay_cmd_rx #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
                      .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .I_clk_10M   (clk),
    .I_rst_n     (rst_n),
    .rxb         (rxb),
    .GA          (ga),
    .O_WEA       (wea),
    .O_WADDR     (waddr),
    .O_WDATA     (wdata),
    .O_frame_err (frame_err),
    .O_err_cnt   (err_cnt),
    .O_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int ch, input logic [23:0] d);
    wr_ev_t ev;
    ev = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == 15 || ch == k + 1) begin
        ev.mask[k]          = 1'b1;
        ev.addr[k*AW +: AW] = AW'(ptr[k]);
        ev.data[k*DW +: DW] = d;
        ptr[k]              = (ptr[k] + 1) % (1 << AW);
      end
    end
    wr_q.push_back(ev);
  endtask

  task automatic exp_error();
    if (exp_err < 255) exp_err++;
    err_q.push_back(8'(exp_err));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxb = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxb = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxb = stop_bit;
    repeat (CPB) @(negedge clk);
    rxb = 1'b1;
  endtask

  task automatic send_frame(input logic [63:0] f, input int bad_idx);
    for (int i = 0; i < 8; i++) begin
      send_byte(f[63-8*i -: 8], (i != bad_idx));
      if (i == bad_idx) break;
    end
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 300 && (wr_q.size() != 0 || err_q.size() != 0); c++) @(negedge clk);
    chk(name, 128'(wr_q.size() + err_q.size()), 128'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wea != '0) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_wea", 128'(wea), 128'd0);
        end else begin
          wr_ev_t ev;
          ev = wr_q.pop_front();
          chk("wea_mask", 128'(wea), 128'(ev.mask));
          for (int k = 0; k < NCH; k++) begin
            if (ev.mask[k]) begin
              chk($sformatf("waddr_ch%0d", k), 128'(waddr[k*AW +: AW]), 128'(ev.addr[k*AW +: AW]));
              chk($sformatf("wdata_ch%0d", k), 128'(wdata[k*DW +: DW]), 128'(ev.data[k*DW +: DW]));
            end
          end
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) chk("unexpected_err", 128'd1, 128'd0);
        else                   chk("err_cnt", 128'(err_cnt), 128'(err_q.pop_front()));
      end
    end
  end

  initial begin
    for (int k = 0; k < NCH; k++) ptr[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_wea", 128'(wea), 128'd0);
    chk("rst_waddr", 128'(waddr), 128'd0);
    chk("rst_wdata", 128'(wdata), 128'd0);
    chk("rst_err", 128'({frame_err, err_cnt, busy}), 128'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    exp_wr(1, 24'h00000a); send_frame(64'h02002000_e100000a, -1); drain("drain_first");
    chk("hold_waddr0", 128'(waddr[AW-1:0]), 128'd0);
    chk("hold_wdata0", 128'(wdata[DW-1:0]), 128'h00000a);

    exp_wr(1, 24'h000014); send_frame(64'h02002000_e1000014, -1);
    exp_wr(2, 24'h000014); send_frame(64'h02002000_e2000014, -1);
    exp_wr(3, 24'h00001e); send_frame(64'h02002000_e300001e, -1);
    exp_wr(4, 24'h000028); send_frame(64'h02002000_e4000028, -1);
    drain("drain_chans");

    send_frame(64'h02002000_d100000a, -1);
    exp_wr(15, 24'h000033); send_frame(64'h02002000_ef000033, -1);
    drain("drain_bcast");

    exp_error(); send_frame(64'h02002000_e2000055, 2);
    exp_wr(2, 24'h000055); send_frame(64'h02002000_e2000055, -1);
    drain("drain_framing");

    for (int i = 0; i < 4; i++) send_byte(8'(64'h02002000_e3000066 >> (56 - 8 * i)), 1'b1);
    repeat (20) @(negedge clk);
    chk("busy_partial", 128'(busy), 128'd1);
    exp_error();
    for (int c = 0; c < TMO + 200 && busy; c++) @(negedge clk);
    chk("busy_after_timeout", 128'(busy), 128'd0);
    exp_wr(3, 24'h000066); send_frame(64'h02002000_e3000066, -1);
    drain("drain_timeout");

    send_frame(64'h02003000_e1000000, -1); ptr[0] = 0;
    exp_wr(1, 24'h000077); send_frame(64'h02002000_e1000077, -1);
    exp_error(); send_frame(64'h02002000_e5000001, -1);
    drain("drain_clr_badch");

    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    rxb = 1'b0;
    repeat (35) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wea", 128'(wea), 128'd0);
    chk("mid_rst_waddr", 128'(waddr), 128'd0);
    chk("mid_rst_wdata", 128'(wdata), 128'd0);
    chk("mid_rst_err_busy", 128'({frame_err, err_cnt, busy}), 128'd0);
    rxb = 1'b1;
    for (int k = 0; k < NCH; k++) ptr[k] = 0;
    exp_err = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_wr(2, 24'h000088); send_frame(64'h02002000_e2000088, -1);
    drain("drain_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
